cu_multicycle: RTL and testbench

Parametrised multicycle control unit, successor to the fixed-width FETCH/DECODE/EXECUTE controller. It sits between the instruction/data RAM and the external ALU. It adds a RAM ready handshake, wait states, jump, branch-if-zero and halt, and has configurable data width, address width and register count. It owns the program counter, the instruction register and the general register file.

---
 rtl/cu_pkg.sv | 41 ++++
 rtl/cu_regfile.sv | 42 ++++
 rtl/cu_multicycle.sv | 215 +++++++++++++++++++++
 tb/tb_cu_multicycle.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states and
// instruction field offsets.
package cu_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StFwait,
        StDecode,
        StExec,
        StMwait,
        StHalt
    } cu_state_e;

    localparam int unsigned OpLdi     = 0;
    localparam int unsigned OpSti     = 1;
    localparam int unsigned OpLd      = 2;
    localparam int unsigned OpSt      = 3;
    localparam int unsigned OpMov     = 4;
    localparam int unsigned OpJmp     = 5;
    localparam int unsigned OpBz      = 6;
    localparam int unsigned OpHlt     = 7;
    localparam int unsigned OpAluBase = 8;

    function automatic int unsigned rd_lsb(int unsigned opsize);
        return opsize;
    endfunction

    function automatic int unsigned rs1_lsb(int unsigned opsize, int unsigned rega);
        return opsize + rega;
    endfunction

    function automatic int unsigned rs2_lsb(int unsigned opsize, int unsigned rega);
        return opsize + 2 * rega;
    endfunction

    // The immediate overlaps rs1/rs2; instructions use one or the other.
    function automatic int unsigned imm_lsb(int unsigned opsize, int unsigned rega);
        return opsize + rega;
    endfunction

endpackage

// File: rtl/cu_regfile.sv
// General register file: two combinational read ports, one synchronous write
// port, synchronous active-high clear.
module cu_regfile
    import cu_pkg::*;
#(
    parameter int unsigned DATAW = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned REGA  = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [REGA-1:0]  waddr_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic [REGA-1:0]  raddr_a_i,
    output logic [DATAW-1:0] rdata_a_o,
    input  logic [REGA-1:0]  raddr_b_i,
    output logic [DATAW-1:0] rdata_b_o
);

    logic [DATAW-1:0] regs_q [NREGS];
    logic [DATAW-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cu_multicycle.sv
// Multicycle control unit: FETCH/FWAIT/DECODE/EXEC/MWAIT/HALT sequencer that owns
// pc, instruction register and register file, driving the RAM and external ALU.
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int unsigned DATAW    = 16,
    parameter int unsigned ADDRW    = 8,
    parameter int unsigned OPSIZE   = 4,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              ramready,
    input  logic [DATAW-1:0]  fromram,
    output logic [DATAW-1:0]  toram,
    output logic [ADDRW-1:0]  addressbus,
    output logic              read,
    output logic              write,
    output logic [OPSIZE-1:0] aluopcode,
    output logic [DATAW-1:0]  aluin1,
    output logic [DATAW-1:0]  aluin2,
    input  logic [DATAW-1:0]  aluout,
    output logic              halted
);

    localparam int unsigned REGA   = $clog2(NREGS);
    localparam int unsigned RdLsb  = rd_lsb(OPSIZE);
    localparam int unsigned Rs1Lsb = rs1_lsb(OPSIZE, REGA);
    localparam int unsigned Rs2Lsb = rs2_lsb(OPSIZE, REGA);
    localparam int unsigned ImmLsb = imm_lsb(OPSIZE, REGA);

    cu_state_e         state_q, state_d;
    logic [ADDRW-1:0]  pc_q, pc_d;
    logic [DATAW-1:0]  ir_q, ir_d;
    logic [ADDRW-1:0]  addr_q, addr_d;
    logic [DATAW-1:0]  toram_q, toram_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [OPSIZE-1:0] aluop_q, aluop_d;
    logic [DATAW-1:0]  aluin1_q, aluin1_d;
    logic [DATAW-1:0]  aluin2_q, aluin2_d;

    logic [OPSIZE-1:0] op;
    logic [REGA-1:0]   rd, rs1, rs2, rb_addr;
    logic [DATAW-1:0]  imm, ra, rb, rf_wdata;
    logic              rf_we, is_alu, is_mem;

    assign op      = ir_q[OPSIZE-1:0];
    assign rd      = ir_q[RdLsb +: REGA];
    assign rs1     = ir_q[Rs1Lsb +: REGA];
    assign rs2     = ir_q[Rs2Lsb +: REGA];
    assign imm     = ir_q >> ImmLsb;
    assign is_alu  = op >= OPSIZE'(OpAluBase);
    assign is_mem  = (op == OPSIZE'(OpLd)) || (op == OPSIZE'(OpSt)) || (op == OPSIZE'(OpSti));
    // Port B serves rs2 for ALU ops, otherwise rd (store address, branch condition).
    assign rb_addr = is_alu ? rs2 : rd;

    cu_regfile #(
        .DATAW (DATAW),
        .NREGS (NREGS),
        .REGA  (REGA)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (reset),
        .we_i      (rf_we & enable),
        .waddr_i   (rd),
        .wdata_i   (rf_wdata),
        .raddr_a_i (rs1),
        .rdata_a_o (ra),
        .raddr_b_i (rb_addr),
        .rdata_b_o (rb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= ADDRW'(RESET_PC);
            ir_q     <= '0;
            addr_q   <= '0;
            toram_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            aluop_q  <= '0;
            aluin1_q <= '0;
            aluin2_q <= '0;
        end else if (enable) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            addr_q   <= addr_d;
            toram_q  <= toram_d;
            read_q   <= read_d;
            write_q  <= write_d;
            aluop_q  <= aluop_d;
            aluin1_q <= aluin1_d;
            aluin2_q <= aluin2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StFwait;
            StFwait:  if (ramready) state_d = StDecode;
            StDecode: begin
                if (is_mem) begin
                    state_d = StMwait;
                end else if (op == OPSIZE'(OpHlt)) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec:   state_d = StFetch;
            StMwait:  if (ramready) state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        toram_d  = toram_q;
        read_d   = read_q;
        write_d  = write_q;
        aluop_d  = aluop_q;
        aluin1_d = aluin1_q;
        aluin2_d = aluin2_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        unique case (state_q)
            StFetch: begin
                addr_d = pc_q;
                read_d = 1'b1;
            end
            StFwait: begin
                if (ramready) begin
                    ir_d   = fromram;
                    read_d = 1'b0;
                    pc_d   = pc_q + ADDRW'(1);
                end
            end
            StDecode: begin
                case (op)
                    OPSIZE'(OpLd): begin
                        addr_d = ra[ADDRW-1:0];
                        read_d = 1'b1;
                    end
                    OPSIZE'(OpSt): begin
                        addr_d  = rb[ADDRW-1:0];
                        toram_d = ra;
                        write_d = 1'b1;
                    end
                    OPSIZE'(OpSti): begin
                        addr_d  = rb[ADDRW-1:0];
                        toram_d = imm;
                        write_d = 1'b1;
                    end
                    default: begin
                        if (is_alu) begin
                            aluop_d  = op;
                            aluin1_d = ra;
                            aluin2_d = rb;
                        end
                    end
                endcase
            end
            StExec: begin
                case (op)
                    OPSIZE'(OpLdi): begin
                        rf_we    = 1'b1;
                        rf_wdata = imm;
                    end
                    OPSIZE'(OpMov): begin
                        rf_we    = 1'b1;
                        rf_wdata = ra;
                    end
                    OPSIZE'(OpJmp): pc_d = imm[ADDRW-1:0];
                    OPSIZE'(OpBz):  if (rb == '0) pc_d = imm[ADDRW-1:0];
                    default: begin
                        if (is_alu) begin
                            rf_we    = 1'b1;
                            rf_wdata = aluout;
                        end
                    end
                endcase
            end
            StMwait: begin
                if (ramready) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (op == OPSIZE'(OpLd)) begin
                        rf_we    = 1'b1;
                        rf_wdata = fromram;
                    end
                end
            end
            default: ;
        endcase
    end

    assign toram      = toram_q;
    assign addressbus = addr_q;
    assign read       = read_q;
    assign write      = write_q;
    assign aluopcode  = aluop_q;
    assign aluin1     = aluin1_q;
    assign aluin2     = aluin2_q;
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_cu_multicycle.sv
// Bench for cu_multicycle: RAM and ALU environment plus an instruction-level
// reference model, with directed programs followed by random programs.
module tb_cu_multicycle;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned OS = 4;
    localparam int unsigned NR = 8;

    logic          clk = 1'b0;
    logic          reset, enable, ramready, read, write, halted;
    logic [DW-1:0] fromram, toram, aluin1, aluin2, aluout;
    logic [AW-1:0] addressbus;
    logic [OS-1:0] aluopcode;

    int n_checks = 0;
    int n_errs   = 0;
    bit frz_en   = 1'b0;

    logic [DW-1:0] mem  [256];
    logic [DW-1:0] mreg [NR];
    logic [AW-1:0] mpc;

    always #5 clk = ~clk;

    cu_multicycle dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .ramready   (ramready),
        .fromram    (fromram),
        .toram      (toram),
        .addressbus (addressbus),
        .read       (read),
        .write      (write),
        .aluopcode  (aluopcode),
        .aluin1     (aluin1),
        .aluin2     (aluin2),
        .aluout     (aluout),
        .halted     (halted)
    );

    function automatic logic [DW-1:0] alu_f(input logic [OS-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            4'd8:    return a + b;
            4'd9:    return a - b;
            4'd10:   return a & b;
            4'd11:   return a | b;
            4'd12:   return a ^ b;
            4'd13:   return a << 1;
            4'd14:   return a >> 1;
            default: return ~a;
        endcase
    endfunction

    assign aluout = alu_f(aluopcode, aluin1, aluin2);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // One enabled clock, optionally preceded by a frozen cycle with junk inputs.
    task automatic tick(input logic rdy, input logic [DW-1:0] data);
        if (frz_en && $urandom_range(0, 4) == 0) begin
            enable   = 1'b0;
            ramready = 1'($urandom_range(0, 1));
            fromram  = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        enable   = 1'b1;
        ramready = rdy;
        fromram  = data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check_eq(tag, 32'(dut.u_regfile.regs_q[i]), 32'(mreg[i]));
        end
    endtask

    task automatic do_reset();
        enable   = 1'b1;
        reset    = 1'b1;
        ramready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mpc   = '0;
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        check_eq("rst_read", 32'(read), 0);
        check_eq("rst_write", 32'(write), 0);
        check_eq("rst_addr", 32'(addressbus), 0);
        check_eq("rst_toram", 32'(toram), 0);
        check_eq("rst_aluop", 32'(aluopcode), 0);
        check_eq("rst_aluin", 32'({aluin1, aluin2}), 0);
        check_eq("rst_halted", 32'(halted), 0);
        check_regs("rst_regs");
    endtask

    // Run one instruction from FETCH with nwf/nwm RAM wait cycles.
    task automatic step_instr(input int nwf, input int nwm, output bit hlt);
        logic [DW-1:0] w, imm, dat;
        logic [AW-1:0] ea;
        int op, rd, rs1, rs2;
        w   = mem[mpc];
        op  = int'(w[3:0]);
        rd  = int'(w[6:4]);
        rs1 = int'(w[9:7]);
        rs2 = int'(w[12:10]);
        imm = w >> 7;
        hlt = 1'b0;
        check_eq("fetch_idle", 32'({read, write}), 0);
        tick(1'($urandom_range(0, 1)), DW'($urandom));
        check_eq("fwait_read", 32'(read), 1);
        check_eq("fetch_addr", 32'(addressbus), 32'(mpc));
        repeat (nwf) begin
            tick(1'b0, DW'($urandom));
            check_eq("fwait_hold", 32'({read, addressbus}), 32'({1'b1, mpc}));
        end
        tick(1'b1, w);
        check_eq("decode_idle", 32'({read, write, halted}), 0);
        mpc = mpc + 1'b1;
        tick(1'($urandom_range(0, 1)), DW'($urandom));
        if (op == 7) begin
            check_eq("hlt_halted", 32'(halted), 1);
            check_eq("hlt_idle", 32'({read, write}), 0);
            hlt = 1'b1;
            return;
        end
        case (op)
            2: begin
                ea = mreg[rs1][AW-1:0];
                check_eq("ld_strobe", 32'({read, write}), 32'(2'b10));
                check_eq("ld_addr", 32'(addressbus), 32'(ea));
                repeat (nwm) begin
                    tick(1'b0, DW'($urandom));
                    check_eq("ld_hold", 32'({read, addressbus}), 32'({1'b1, ea}));
                end
                tick(1'b1, mem[ea]);
                mreg[rd] = mem[ea];
            end
            1, 3: begin
                ea  = mreg[rd][AW-1:0];
                dat = (op == 1) ? imm : mreg[rs1];
                check_eq("st_strobe", 32'({read, write}), 32'(2'b01));
                check_eq("st_addr", 32'(addressbus), 32'(ea));
                check_eq("st_data", 32'(toram), 32'(dat));
                repeat (nwm) begin
                    tick(1'b0, DW'($urandom));
                    check_eq("st_hold", 32'({write, addressbus}), 32'({1'b1, ea}));
                end
                tick(1'b1, DW'($urandom));
                mem[ea] = dat;
            end
            0, 4, 5, 6: begin
                check_eq("exec_idle", 32'({read, write}), 0);
                if (op == 0) mreg[rd] = imm;
                if (op == 4) mreg[rd] = mreg[rs1];
                if (op == 5 || (op == 6 && mreg[rd] == '0)) mpc = imm[AW-1:0];
                tick(1'($urandom_range(0, 1)), DW'($urandom));
            end
            default: begin
                check_eq("alu_op", 32'(aluopcode), 32'(op));
                check_eq("alu_in1", 32'(aluin1), 32'(mreg[rs1]));
                check_eq("alu_in2", 32'(aluin2), 32'(mreg[rs2]));
                mreg[rd] = alu_f(OS'(op), mreg[rs1], mreg[rs2]);
                tick(1'($urandom_range(0, 1)), DW'($urandom));
            end
        endcase
        check_regs("regs");
    endtask

    task automatic halt_checks();
        repeat (6) begin
            enable   = 1'($urandom_range(0, 1));
            ramready = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check_eq("halt_stay", 32'({halted, read, write}), 32'(3'b100));
        end
        enable = 1'b1;
    endtask

    initial begin
        bit h;
        logic [DW-1:0] w;
        reset    = 1'b1;
        enable   = 1'b1;
        ramready = 1'b0;
        fromram  = '0;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        mem[0]     = 16'h0290;  // LDI r1,5
        mem[1]     = 16'h2010;  // LDI r1,0x40
        mem[2]     = 16'h0F91;  // STI [r1],0x1F
        mem[3]     = 16'h00A2;  // LD r2,[r1]
        mem[4]     = 16'h0190;  // LDI r1,3
        mem[5]     = 16'h01A0;  // LDI r2,3
        mem[6]     = 16'h08B9;  // SUB r3,r1,r2
        mem[7]     = 16'h1036;  // BZ r3,0x20
        mem[8'h20] = 16'h0816;  // BZ r1,0x10
        mem[8'h21] = 16'h0007;  // HLT
        @(negedge clk);

        do_reset();
        step_instr(0, 0, h);
        check_eq("boot_r1", 32'(dut.u_regfile.regs_q[1]), 5);
        do_reset();
        step_instr(3, 0, h);
        check_eq("wait_r1", 32'(dut.u_regfile.regs_q[1]), 5);

        frz_en = 1'b1;
        step_instr(0, 0, h);
        step_instr(1, 2, h);
        step_instr(0, 1, h);
        check_eq("ld_r2", 32'(dut.u_regfile.regs_q[2]), 32'h1F);
        for (int i = 0; i < 3; i++) step_instr(0, 0, h);
        check_eq("alu_r3", 32'(dut.u_regfile.regs_q[3]), 0);
        step_instr(0, 0, h);
        check_eq("bz_taken", 32'(dut.pc_q), 32'h20);
        step_instr(0, 0, h);
        check_eq("bz_fall", 32'(dut.pc_q), 32'h21);
        step_instr(0, 0, h);
        check_eq("hlt_seen", 32'(h), 1);
        halt_checks();

        // Reset while a store waits in MWAIT.
        mem[0] = 16'h2010;
        mem[1] = 16'h0F91;
        do_reset();
        step_instr(0, 0, h);
        frz_en = 1'b0;
        tick(1'b0, '0);
        tick(1'b1, mem[1]);
        tick(1'b0, '0);
        check_eq("mw_write", 32'({write, addressbus, toram}), 32'({1'b1, 8'h40, 16'h1F}));
        tick(1'b0, '0);
        check_eq("mw_hold", 32'(write), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_strobe", 32'({read, write}), 0);
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        check_regs("abort_regs");
        mpc = '0;
        frz_en = 1'b1;
        step_instr(0, 0, h);

        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 256; a++) begin
                w = DW'($urandom);
                if (w[3:0] == 4'd7 && $urandom_range(0, 9) != 0) w[3:0] = 4'd8;
                mem[a] = w;
            end
            do_reset();
            h = 1'b0;
            for (int k = 0; k < 60 && !h; k++) begin
                step_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, h);
            end
            if (h) halt_checks();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
